// File: rtl/fifo_rd_stream_if.sv
// Valid/ready beat stream carrying data plus an end-of-burst flag.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO drain stage. It turns a 1-cycle-latency rd_en/dout FIFO port into a
// full-throughput valid/ready stream. It uses a 2-entry output buffer and an
// in-flight read flag, and it frames beats into bursts of BURST_LEN with a
// last flag.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  fifo_rd_stream_if.master      m,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  burst_done,
  output logic [1:0]            buf_level
);

  localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  head_q;
  logic [1:0]            level_q;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  beat_cnt_q;
  logic                  burst_done_q;

  logic       pop;
  logic [2:0] occ_after_pop;
  logic       tail;
  logic       at_last;

  // Issue a read only if the word it returns is sure to have a free slot.
  always_comb begin
    pop           = m.valid & m.ready;
    // pop implies level_q >= 1, so this never wraps below zero.
    occ_after_pop = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en    = ~rst & ~fifo_empty & (occ_after_pop < 3'd2);
    // Slot just past the newest entry; with level 2 it equals head, which
    // cannot coincide with a capture because level + inflight stays <= 2.
    tail          = head_q ^ level_q[0];
    at_last       = (beat_cnt_q == LastBeat);
  end

  assign m.valid    = (level_q != 2'd0);
  assign m.data     = buf_q[head_q];
  assign m.last     = m.valid & at_last;
  assign beat_cnt   = beat_cnt_q;
  assign burst_done = burst_done_q;
  assign buf_level  = level_q;

  // Buffer, in-flight tracking and burst framing state.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      head_q       <= 1'b0;
      level_q      <= 2'd0;
      inflight_q   <= 1'b0;
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (inflight_q) begin
        buf_q[tail] <= fifo_dout;
      end
      if (pop) begin
        head_q     <= ~head_q;
        beat_cnt_q <= at_last ? '0 : beat_cnt_q + CNT_WIDTH'(1);
      end
      level_q      <= occ_after_pop[1:0];
      burst_done_q <= pop & at_last;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (BURST_LEN 16 and 1), each fed by
// a queue-based FIFO model and checked beat by beat against a word-order
// scoreboard and counts of issued reads and accepted beats.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty [2];
  logic [DW-1:0] fifo_dout  [2];
  logic          fifo_rd_en [2];
  logic          m_ready    [2];
  logic          m_valid    [2];
  logic [DW-1:0] m_data     [2];
  logic          m_last     [2];
  logic [CW-1:0] beat_cnt   [2];
  logic          burst_done [2];
  logic [1:0]    buf_level  [2];

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if0 ();
  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if1 ();

  assign s_if0.ready = m_ready[0];
  assign s_if1.ready = m_ready[1];
  assign m_valid[0]  = s_if0.valid;
  assign m_valid[1]  = s_if1.valid;
  assign m_data[0]   = s_if0.data;
  assign m_data[1]   = s_if1.data;
  assign m_last[0]   = s_if0.last;
  assign m_last[1]   = s_if1.last;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(16), .CNT_WIDTH(CW)) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty[0]),
    .fifo_dout  (fifo_dout[0]),
    .fifo_rd_en (fifo_rd_en[0]),
    .m          (s_if0),
    .beat_cnt   (beat_cnt[0]),
    .burst_done (burst_done[0]),
    .buf_level  (buf_level[0])
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(1), .CNT_WIDTH(CW)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty[1]),
    .fifo_dout  (fifo_dout[1]),
    .fifo_rd_en (fifo_rd_en[1]),
    .m          (s_if1),
    .beat_cnt   (beat_cnt[1]),
    .burst_done (burst_done[1]),
    .buf_level  (buf_level[1])
  );

  initial forever #5 clk = ~clk;

  // Reference state per instance
  logic [DW-1:0] fifo_q [2][$];
  logic [DW-1:0] exp_q  [2][$];
  int            issued     [2];
  int            accepted   [2];
  int            rd_pulses  [2];
  int            dut_bursts [2];
  int            first_acc  [2];
  int            last_acc   [2];
  bit            inflight   [2];
  bit            prev_lastp [2];
  bit            prev_stall [2];
  logic [DW-1:0] prev_data  [2];
  int            cyc;
  int            n_tests;
  int            n_fail;

  function automatic int bl_of(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      fifo_q[d].delete();
      exp_q[d].delete();
      issued[d]     = 0;
      accepted[d]   = 0;
      inflight[d]   = 1'b0;
      prev_lastp[d] = 1'b0;
      prev_stall[d] = 1'b0;
      fifo_empty[d] = 1'b1;
    end
  endtask

  task automatic push(input int d, input logic [DW-1:0] val);
    fifo_q[d].push_back(val);
    exp_q[d].push_back(val);
    fifo_empty[d] = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic          rd_s  [2];
    logic          pop_s [2];
    logic          v_s   [2];
    logic          r_s   [2];
    logic [DW-1:0] d_s   [2];
    logic          rst_s;
    int            lvl;
    int            bl;
    @(negedge clk);
    rst_s = rst;
    for (int d = 0; d < 2; d++) begin
      bl       = bl_of(d);
      lvl      = issued[d] - int'(inflight[d]) - accepted[d];
      v_s[d]   = m_valid[d];
      r_s[d]   = m_ready[d];
      rd_s[d]  = fifo_rd_en[d];
      d_s[d]   = m_data[d];
      pop_s[d] = v_s[d] & r_s[d] & ~rst_s;
      check("buf_level", 32'(buf_level[d]), 32'(lvl));
      check("m_valid", 32'(v_s[d]), 32'(lvl != 0));
      check("beat_cnt", 32'(beat_cnt[d]), 32'(accepted[d] % bl));
      check("m_last", 32'(m_last[d]), 32'((lvl != 0) && (accepted[d] % bl == bl - 1)));
      check("burst_done", 32'(burst_done[d]), 32'(prev_lastp[d]));
      check("rd_en", 32'(rd_s[d]),
            32'(!rst_s && fifo_q[d].size() != 0 && (lvl + int'(inflight[d]) - int'(v_s[d] & r_s[d])) < 2));
      check("no_underflow", 32'(rd_s[d] && fifo_q[d].size() == 0), 32'(0));
      check("occupancy_le2", 32'(lvl + int'(inflight[d]) <= 2), 32'(1));
      if (prev_stall[d]) check("hold_data", d_s[d], prev_data[d]);
      if (pop_s[d]) begin
        if (exp_q[d].size() == 0) check("spurious_beat", 32'(1), 32'(0));
        else check("m_data", d_s[d], exp_q[d].pop_front());
        if (first_acc[d] < 0) first_acc[d] = cyc;
        last_acc[d] = cyc;
      end
      if (rd_s[d] === 1'b1) rd_pulses[d]++;
      if (burst_done[d] === 1'b1) dut_bursts[d]++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      reset_model();
    end else begin
      for (int d = 0; d < 2; d++) begin
        bl = bl_of(d);
        if (rd_s[d] === 1'b1 && fifo_q[d].size() != 0) begin
          fifo_dout[d] = fifo_q[d].pop_front();
          issued[d]++;
        end
        inflight[d]   = (rd_s[d] === 1'b1);
        prev_lastp[d] = pop_s[d] && (accepted[d] % bl == bl - 1);
        if (pop_s[d]) accepted[d]++;
        prev_stall[d] = v_s[d] & ~r_s[d];
        prev_data[d]  = d_s[d];
        fifo_empty[d] = (fifo_q[d].size() == 0);
      end
    end
  endtask

  task automatic run_until(input int d, input int target, input int budget);
    int n = 0;
    while (accepted[d] < target && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(accepted[d]), 32'(target));
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_rd_en", 32'(fifo_rd_en[d]), 32'(0));
    check("rst_m_valid", 32'(m_valid[d]), 32'(0));
    check("rst_m_data", m_data[d], 32'(0));
    check("rst_m_last", 32'(m_last[d]), 32'(0));
    check("rst_beat_cnt", 32'(beat_cnt[d]), 32'(0));
    check("rst_burst_done", 32'(burst_done[d]), 32'(0));
    check("rst_buf_level", 32'(buf_level[d]), 32'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int b0;
    int r0;
    int push_cyc;
    int target;
    int written;
    int n;

    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_ready[d]    = 1'b0;
      fifo_dout[d]  = '0;
      rd_pulses[d]  = 0;
      dut_bursts[d] = 0;
      first_acc[d]  = -1;
      last_acc[d]   = -1;
    end
    reset_model();
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    check_reset_outputs(0);
    check_reset_outputs(1);

    // Basic: 40 words, ready held high
    m_ready[0]   = 1'b1;
    b0           = dut_bursts[0];
    first_acc[0] = -1;
    push_cyc     = cyc;
    for (int i = 0; i < 40; i++) push(0, 32'(i));
    run_until(0, 40, 100);
    repeat (3) cycle();
    check("basic_latency", 32'(first_acc[0] - push_cyc), 32'(2));
    check("basic_rate", 32'(last_acc[0] - first_acc[0]), 32'(39));
    check("basic_bursts", 32'(dut_bursts[0] - b0), 32'(2));
    check("basic_beat_cnt", 32'(beat_cnt[0]), 32'(8));

    // Backpressure: 10 words, ready low for 20 cycles
    m_ready[0] = 1'b0;
    r0 = rd_pulses[0];
    for (int i = 0; i < 10; i++) push(0, 32'(i));
    repeat (20) cycle();
    check("bp_reads", 32'(rd_pulses[0] - r0), 32'(2));
    check("bp_level", 32'(buf_level[0]), 32'(2));
    check("bp_valid", 32'(m_valid[0]), 32'(1));
    check("bp_data", m_data[0], 32'(0));
    m_ready[0] = 1'b1;
    run_until(0, 50, 60);
    check("bp_leftover", 32'(exp_q[0].size()), 32'(0));

    // Random: 2000 words, random ready and writes
    target  = accepted[0] + 2000;
    written = 0;
    n       = 0;
    while (accepted[0] < target && n < 20000) begin
      m_ready[0] = 1'($urandom_range(0, 1));
      if (written < 2000 && fifo_q[0].size() < 32 && $urandom_range(0, 1) == 1) begin
        push(0, $urandom());
        written++;
      end
      cycle();
      n++;
    end
    check("rand_done", 32'(accepted[0]), 32'(target));
    check("rand_leftover", 32'(exp_q[0].size()), 32'(0));

    // Starvation mid-burst
    m_ready[0] = 1'b0;
    pulse_reset();
    m_ready[0] = 1'b1;
    b0 = dut_bursts[0];
    for (int i = 0; i < 5; i++) push(0, 32'(100 + i));
    run_until(0, 5, 20);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("starve_hold", 32'(beat_cnt[0]), 32'(5));
    end
    for (int i = 0; i < 11; i++) push(0, 32'(105 + i));
    run_until(0, 16, 40);
    repeat (3) cycle();
    check("starve_bursts", 32'(dut_bursts[0] - b0), 32'(1));
    check("starve_beat_cnt", 32'(beat_cnt[0]), 32'(0));

    // Reset mid-burst with a full buffer
    m_ready[0] = 1'b0;
    pulse_reset();
    m_ready[0] = 1'b1;
    for (int i = 0; i < 20; i++) push(0, 32'(200 + i));
    run_until(0, 7, 30);
    m_ready[0] = 1'b0;
    repeat (4) cycle();
    check("mid_level", 32'(buf_level[0]), 32'(2));
    check("mid_beat_cnt", 32'(beat_cnt[0]), 32'(7));
    pulse_reset();
    check_reset_outputs(0);
    b0 = dut_bursts[0];
    m_ready[0] = 1'b1;
    for (int i = 0; i < 20; i++) push(0, 32'(300 + i));
    run_until(0, 20, 60);
    repeat (3) cycle();
    check("mid_bursts", 32'(dut_bursts[0] - b0), 32'(1));
    check("mid_beat_cnt_end", 32'(beat_cnt[0]), 32'(4));

    // BURST_LEN = 1 instance
    b0 = dut_bursts[1];
    m_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) push(1, 32'(400 + i));
    run_until(1, 4, 20);
    repeat (3) cycle();
    check("bl1_bursts", 32'(dut_bursts[1] - b0), 32'(4));
    check("bl1_beat_cnt", 32'(beat_cnt[1]), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
